pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle (ALU result, addresses) and a control bundle (reg_write, mem_to_reg, branch, rd_addr).
- Adds over plain stage registers: valid/ready flow control, flush-to-bubble that zeroes control, and an optional skid entry that breaks the combinational ready path at full throughput.

Parameters:
- DATA_W, 64: width of the data bundle (held on flush).
- CTRL_W, 9: width of the control bundle (zeroed on flush and reset).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all held entries and incoming beat; synchronous.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat this cycle.
- in_data_i  in  DATA_W  upstream data bundle.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- out_valid_o  out  1  downstream beat valid.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DATA_W  head-entry data.
- out_ctrl_o  out  CTRL_W  head-entry control; all zero whenever out_valid_o=0.
- occ_o  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (async, rst_i=1):
  - out_valid_o=0, out_data_o=0, out_ctrl_o=0, occ_o=0.
  - In_ready_o=1 (SKID=1: register resets to 1; SKID=0: follows from empty).
  - Skid entry cleared.
  - Takes effect immediately, mid-transfer included; no beat survives.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - Both sampled at the rising edge.
- Latency: an accepted beat appears on out_* the cycle after acceptance, provided the stage was empty or drained that cycle.
- Throughput: 1 beat/cycle sustained while out_ready_i=1.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Head loads on input transfer.
  - Head invalidates on output transfer without input transfer.
- SKID=1 states:
  - EMPTY: occ=0, in_ready=1.
    - input transfer -> ONE.
  - ONE: occ=1, head valid, in_ready=1.
    - in only -> TWO; beat goes to skid, in_ready_o deasserts next cycle.
    - out only -> EMPTY.
    - in & out -> ONE; head reloads with the new beat.
  - TWO: occ=2, in_ready=0.
    - out transfer -> ONE; skid moves to head, in_ready_o reasserts next cycle.
  - in_ready_o is a flop output equal to ~skid_valid; no combinational path from out_ready_i.
- Ordering: strict FIFO; skid contents always leave after head.
- Flush (synchronous, highest priority below reset):
  - Next edge: occ=0, out_valid_o=0, out_ctrl_o=0, skid cleared, state EMPTY.
  - A simultaneous input transfer is dropped.
  - A simultaneous output transfer still counts downstream (head visible that cycle).
  - out_data_o holds its last value.
  - in_ready_o=1 the cycle after flush.
- Stall: out_ready_i=0 with out_valid_o=1 holds out_data_o/out_ctrl_o stable until transfer. Holding is required; out_* must not change while valid and not ready.
- No beat is duplicated or lost except by flush/reset.
- Widths: data/ctrl pass through unmodified; no arithmetic. occ_o never exceeds 2, or 1 when SKID=0.

Test Plan:
- Reset mid-stream (SKID=1, occ=2, rst_i pulsed between edges) -> outputs zero immediately, occ_o=0, in_ready_o=1; next accepted beat 0xA5 appears one cycle later.
- Streaming: 8 beats data=0..7, ctrl=0x1FF, out_ready_i=1 -> out_data_o=0..7 on consecutive cycles, one-cycle latency, in_ready_o constant 1.
- Backpressure (SKID=1): out_ready_i=0 for 3 cycles while sending 0x11,0x22,0x33 -> 0x11 head, 0x22 skid, in_ready_o=0 after 2nd accept, 0x33 held upstream; release -> 0x11,0x22,0x33 in order, none lost.
- Flush with simultaneous input: occ=2, flush_i=1 and in_valid_i=1 data=0x44 -> next cycle occ_o=0, out_ctrl_o=0, 0x44 never emitted, in_ready_o=1.
- SKID=0 combinational ready: occ=1, out_ready_i toggled 0->1 within cycle -> in_ready_o follows same cycle; back-to-back transfer at full rate.
- Stall stability: out_valid_o=1, out_ready_i=0 for 5 cycles with in_* randomised -> out_data_o/out_ctrl_o unchanged each cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with flush-to-bubble and optional skid entry
//   clk_i, rst_i (async, active-high), flush_i (sync bubble insert)
//   in_valid_i/in_ready_o/in_data_i/in_ctrl_i   upstream beat
//   out_valid_o/out_ready_i/out_data_o/out_ctrl_o downstream beat (ctrl zero when invalid)
//   occ_o  entries held (0..2)
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occ_o
);
  logic              head_v_q, head_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire, head_free, skid_load;
  // With the skid entry, ready is a flop (~skid valid); without it, ready looks through to downstream.
  assign in_ready_o  = (SKID != 0) ? rdy_q : (~head_v_q | out_ready_i);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = head_v_q & out_ready_i;
  assign head_free   = ~head_v_q | out_fire;
  // A beat arriving while the head is held parks in the skid entry; unreachable when SKID=0.
  assign skid_load   = ~head_free & in_fire;
  assign out_valid_o = head_v_q;
  assign out_data_o  = head_data_q;
  assign out_ctrl_o  = head_v_q ? head_ctrl_q : '0;
  assign occ_o       = {1'b0, head_v_q} + {1'b0, skid_v_q};
  always_comb begin
    head_v_d    = ~flush_i & (head_free ? (skid_v_q | in_fire) : 1'b1);
    head_data_d = (flush_i | ~head_free) ? head_data_q :
                  skid_v_q ? skid_data_q : in_fire ? in_data_i : head_data_q;
    head_ctrl_d = flush_i ? '0 : ~head_free ? head_ctrl_q :
                  skid_v_q ? skid_ctrl_q : in_fire ? in_ctrl_i : head_ctrl_q;
    skid_v_d    = ~flush_i & ~head_free & (skid_v_q | in_fire);
    skid_data_d = (~flush_i & skid_load) ? in_data_i : skid_data_q;
    skid_ctrl_d = flush_i ? '0 : skid_load ? in_ctrl_i : skid_ctrl_q;
    rdy_d       = ~skid_v_d;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      rdy_q       <= 1'b1;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      head_v_q    <= head_v_d;
      skid_v_q    <= skid_v_d;
      rdy_q       <= rdy_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench driving a SKID=1 and a SKID=0 instance with shared stimulus
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 9;
  logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic [CW-1:0] in_ctrl_i = '0;
  logic          rdy [2];
  logic          ov  [2];
  logic [DW-1:0] od  [2];
  logic [CW-1:0] oc  [2];
  logic [1:0]    occ [2];
  int errs = 0, checks = 0;
  bit rst_evt = 1'b1;
  logic [72:0]   m    [2][3];
  int            n    [2];
  logic [DW-1:0] held [2];
  always #5 clk_i = ~clk_i;
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy[0]), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(ov[0]), .out_ready_i(out_ready_i), .out_data_o(od[0]), .out_ctrl_o(oc[0]),
    .occ_o(occ[0])
  );
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_flow (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy[1]), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(ov[1]), .out_ready_i(out_ready_i), .out_data_o(od[1]), .out_ctrl_o(oc[1]),
    .occ_o(occ[1])
  );
  task automatic chk(input string nm, input int k, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask
  // Model: each DUT is an ordered list of at most 2 (SKID=1) or 1 (SKID=0) beats.
  always @(negedge clk_i) begin : mon
    logic er;
    for (int k = 0; k < 2; k++) begin
      if (rst_evt) begin
        n[k] = 0;
        held[k] = '0;
      end
      er = (k == 0) ? (n[k] < 2) : (n[k] == 0 || out_ready_i);
      chk("occ", k, 73'(occ[k]), 73'(n[k]));
      chk("out_valid", k, 73'(ov[k]), 73'(n[k] > 0));
      chk("in_ready", k, 73'(rdy[k]), 73'(er));
      if (n[k] > 0) begin
        if (out_ready_i) chk("pop", k, {oc[k], od[k]}, m[k][0]);
        else chk("head_hold", k, {oc[k], od[k]}, m[k][0]);
        held[k] = m[k][0][DW-1:0];
        if (out_ready_i) begin
          m[k][0] = m[k][1];
          m[k][1] = m[k][2];
          n[k]--;
        end
      end else chk("idle", k, {oc[k], od[k]}, {9'd0, held[k]});
      if (flush_i) n[k] = 0;
      else if (in_valid_i && er) begin
        m[k][n[k]] = {in_ctrl_i, in_data_i};
        n[k]++;
      end
    end
    rst_evt = 1'b0;
  end
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic r, input logic f);
    @(posedge clk_i);
    #1;
    in_valid_i = v;
    in_data_i = d;
    in_ctrl_i = c;
    out_ready_i = r;
    flush_i = f;
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'(i), 9'h1FF, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 64'h11, 9'h011, 1'b0, 1'b0);
    cyc(1'b1, 64'h22, 9'h022, 1'b0, 1'b0);
    cyc(1'b1, 64'h33, 9'h033, 1'b0, 1'b0);
    cyc(1'b1, 64'h33, 9'h033, 1'b0, 1'b0);
    cyc(1'b1, 64'h33, 9'h033, 1'b1, 1'b0);
    cyc(1'b1, 64'h33, 9'h033, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 64'hAA, 9'h0AA, 1'b0, 1'b0);
    cyc(1'b1, 64'hBB, 9'h0BB, 1'b0, 1'b0);
    cyc(1'b1, 64'h44, 9'h044, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 64'h01, 9'h001, 1'b0, 1'b0);
    cyc(1'b1, 64'h02, 9'h002, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b1;
    in_data_i = 64'hA5;
    in_ctrl_i = 9'h0A5;
    out_ready_i = 1'b1;
    flush_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 73'(ov[k]), 73'd0);
      chk("rst_out", k, {oc[k], od[k]}, 73'd0);
      chk("rst_occ", k, 73'(occ[k]), 73'd0);
      chk("rst_ready", k, 73'(rdy[k]), 73'd1);
    end
    rst_i = 1'b0;
    rst_evt = 1'b1;
    repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 64'h55, 9'h055, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    #1 chk("comb_ready_lo", 1, 73'(rdy[1]), 73'd0);
    out_ready_i = 1'b1;
    #1 chk("comb_ready_hi", 1, 73'(rdy[1]), 73'd1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 64'h60 + 64'(i), 9'h060 + 9'(i), 1'b1, 1'b0);
    cyc(1'b1, 64'h77, 9'h077, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'($urandom), {$urandom, $urandom}, 9'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(3) != 0), {$urandom, $urandom}, 9'($urandom),
          1'($urandom_range(2) != 0), 1'($urandom_range(19) == 0));
    repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
